cook_timer: RTL and testbench

Countdown cook timer for the microwave controller; it produces the `timer_done` input that the magnetron control logic consumes. It holds a BCD minutes:seconds value loaded from the keypad path, counts down one second per prescaled tick while `mag_on` is high, and pauses while `mag_on` is low. When the count reaches 00:00 it asserts `timer_done` and emits a one-cycle `done_pulse` for the beeper.

---
 rtl/cook_timer.sv | 133 +++++++++++++
 tb/tb_cook_timer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cook_timer.sv
// BCD mm:ss countdown timer for the microwave controller; counts while mag_on is high.
// Optional quick-add (+30 s, saturating at 99:59) is built when COOK_TIMER_ADD30_EN is defined.
module cook_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       mag_on,
`ifdef COOK_TIMER_ADD30_EN
  input  logic       add30,
`endif
  output logic [7:0] mm_out,
  output logic [7:0] ss_out,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       load_err
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [15:0]   cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    state_q, state_d;
  logic          pulse_q, pulse_d;
  logic          err_q, err_d;
  logic          running, load_ok, digits_ok;

  // Decrement {mm,ss} by one second with BCD borrow; caller guarantees nonzero input.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mh, ml, sh, sl;
    {mh, ml, sh, sl} = t;
    if ({sh, sl} == 8'h00) begin
      sh = 4'd5;
      sl = 4'd9;
      if (ml == 4'd0) begin
        ml = 4'd9;
        mh = mh - 4'd1;
      end else begin
        ml = ml - 4'd1;
      end
    end else if (sl == 4'd0) begin
      sl = 4'd9;
      sh = sh - 4'd1;
    end else begin
      sl = sl - 4'd1;
    end
    return {mh, ml, sh, sl};
  endfunction

`ifdef COOK_TIMER_ADD30_EN
  function automatic logic [15:0] bcd_add30(input logic [15:0] t);
    logic [3:0] mh, ml, sh, sl;
    logic       carry;
    {mh, ml, sh, sl} = t;
    sh    = sh + 4'd3;
    carry = (sh >= 4'd6);
    if (carry) sh = sh - 4'd6;
    if (carry) begin
      if ({mh, ml} == 8'h99) return 16'h9959;
      if (ml == 4'd9) begin
        ml = 4'd0;
        mh = mh + 4'd1;
      end else begin
        ml = ml + 4'd1;
      end
    end
    return {mh, ml, sh, sl};
  endfunction
`endif

  assign digits_ok = (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                     (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9);
  assign load_ok   = load && !mag_on && digits_ok;
  assign running   = (state_q != IDLE) && mag_on;

  always_comb begin
    cnt_d   = cnt_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    err_d   = load && !load_ok;
    if (load_ok) begin
      cnt_d   = {load_mm, load_ss};
      presc_d = '0;
`ifdef COOK_TIMER_ADD30_EN
    end else if (add30) begin
      cnt_d = bcd_add30(cnt_q);
`endif
    end else if (running) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        cnt_d   = bcd_dec(cnt_q);
        pulse_d = (cnt_d == 16'h0000);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (cnt_d == 16'h0000) state_d = IDLE;
    else if (mag_on)       state_d = RUN;
    else                   state_d = ARMED;
  end

  always_ff @(posedge clk) begin
    if (!resetn || !clearn) begin
      cnt_q   <= 16'h0000;
      presc_q <= '0;
      state_q <= IDLE;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      state_q <= state_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign mm_out     = cnt_q[15:8];
  assign ss_out     = cnt_q[7:0];
  assign timer_done = (state_q == IDLE);
  assign done_pulse = pulse_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICKS_PER_SEC=4; add30 cases build with COOK_TIMER_ADD30_EN.
module tb_cook_timer;
  logic       clk = 1'b0;
  logic       resetn, clearn, load, mag_on;
  logic [7:0] load_mm, load_ss;
  logic [7:0] mm_out, ss_out;
  logic       timer_done, done_pulse, load_err;
`ifdef COOK_TIMER_ADD30_EN
  logic       add30 = 1'b0;
`endif
  int n_chk = 0;
  int n_bad = 0;

  cook_timer #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .resetn(resetn), .clearn(clearn), .load(load),
    .load_mm(load_mm), .load_ss(load_ss), .mag_on(mag_on),
`ifdef COOK_TIMER_ADD30_EN
    .add30(add30),
`endif
    .mm_out(mm_out), .ss_out(ss_out), .timer_done(timer_done),
    .done_pulse(done_pulse), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
    load_mm = mm;
    load_ss = ss;
    load    = 1'b1;
    step(1);
    load    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; clearn = 1'b1; load = 1'b0; mag_on = 1'b0;
    load_mm = 8'h00; load_ss = 8'h00;
    #2;
    step(1);
    chk("rst_cnt",   {mm_out, ss_out}, 16'h0000);
    chk("rst_done",  16'(timer_done), 16'd1);
    chk("rst_pulse", 16'(done_pulse), 16'd0);
    chk("rst_err",   16'(load_err),   16'd0);
    resetn = 1'b1;

    // countdown 00:02 -> 00:00
    do_load(8'h00, 8'h02);
    chk("ld_cnt",  {mm_out, ss_out}, 16'h0002);
    chk("ld_done", 16'(timer_done), 16'd0);
    mag_on = 1'b1;
    step(3);
    chk("cd_hold3", {mm_out, ss_out}, 16'h0002);
    step(1);
    chk("cd_01", {mm_out, ss_out}, 16'h0001);
    step(3);
    chk("cd_hold7", {mm_out, ss_out}, 16'h0001);
    chk("cd_nopulse", 16'(done_pulse), 16'd0);
    step(1);
    chk("cd_00",    {mm_out, ss_out}, 16'h0000);
    chk("cd_done",  16'(timer_done), 16'd1);
    chk("cd_pulse", 16'(done_pulse), 16'd1);
    step(1);
    chk("cd_pulse_fall", 16'(done_pulse), 16'd0);
    chk("cd_floor", {mm_out, ss_out}, 16'h0000);
    mag_on = 1'b0;

    // BCD borrows
    do_load(8'h01, 8'h00);
    mag_on = 1'b1;
    step(4);
    chk("borrow_min", {mm_out, ss_out}, 16'h0059);
    mag_on = 1'b0;
    do_load(8'h00, 8'h10);
    mag_on = 1'b1;
    step(4);
    chk("borrow_sec", {mm_out, ss_out}, 16'h0009);
    mag_on = 1'b0;

    // pause keeps partial second
    do_load(8'h00, 8'h05);
    mag_on = 1'b1;
    step(2);
    mag_on = 1'b0;
    step(10);
    chk("pause_hold", {mm_out, ss_out}, 16'h0005);
    mag_on = 1'b1;
    step(1);
    chk("resume_1", {mm_out, ss_out}, 16'h0005);
    step(1);
    chk("resume_2", {mm_out, ss_out}, 16'h0004);
    mag_on = 1'b0;

    // invalid digits rejected
    do_load(8'h00, 8'h6A);
    chk("bad_err", 16'(load_err), 16'd1);
    chk("bad_cnt", {mm_out, ss_out}, 16'h0004);
    step(1);
    chk("bad_err_fall", 16'(load_err), 16'd0);
    do_load(8'hA0, 8'h00);
    chk("bad_mm_err", 16'(load_err), 16'd1);
    chk("bad_mm_cnt", {mm_out, ss_out}, 16'h0004);

    // load while running rejected, countdown continues
    mag_on = 1'b1;
    step(1);
    do_load(8'h00, 8'h30);
    chk("run_ld_err", 16'(load_err), 16'd1);
    chk("run_ld_cnt", {mm_out, ss_out}, 16'h0004);
    step(1);
    chk("run_ld_err_fall", 16'(load_err), 16'd0);
    step(1);
    chk("run_ld_tick", {mm_out, ss_out}, 16'h0003);
    mag_on = 1'b0;

    // clear with load in same cycle
    do_load(8'h05, 8'h00);
    chk("ld_0500", {mm_out, ss_out}, 16'h0500);
    clearn = 1'b0;
    do_load(8'h00, 8'h07);
    clearn = 1'b1;
    chk("clr_cnt",   {mm_out, ss_out}, 16'h0000);
    chk("clr_err",   16'(load_err),   16'd0);
    chk("clr_done",  16'(timer_done), 16'd1);
    chk("clr_pulse", 16'(done_pulse), 16'd0);

    // zero load: done but no pulse
    do_load(8'h00, 8'h03);
    do_load(8'h00, 8'h00);
    chk("zld_done",  16'(timer_done), 16'd1);
    chk("zld_pulse", 16'(done_pulse), 16'd0);

`ifdef COOK_TIMER_ADD30_EN
    add30 = 1'b1;
    step(1);
    add30 = 1'b0;
    chk("a30_idle", {mm_out, ss_out}, 16'h0030);
    chk("a30_idle_done", 16'(timer_done), 16'd0);
    do_load(8'h00, 8'h45);
    add30 = 1'b1;
    step(1);
    add30 = 1'b0;
    chk("a30_carry", {mm_out, ss_out}, 16'h0115);
    do_load(8'h99, 8'h40);
    add30 = 1'b1;
    step(1);
    add30 = 1'b0;
    chk("a30_sat", {mm_out, ss_out}, 16'h9959);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
